// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for data_mem_responder: channel FSM states, counter width
// and the LFSR seed/taps used by the optional latency jitter.
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StBusy    = 2'd1,
        StRespond = 2'd2,
        StRelease = 2'd3
    } chan_state_e;

    // Wide enough for LATENCY-1 (max 14) plus up to 3 jitter cycles.
    localparam int unsigned CntBits = 5;

    localparam logic [7:0] LfsrSeed = 8'h5A;
    // x^8 + x^6 + x^5 + x^4 + 1, left-shifting Fibonacci form.
    localparam logic [7:0] LfsrTaps = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LfsrTaps)};
    endfunction

endpackage

// File: rtl/mem_resp_channel.sv
// One request/response channel: IDLE -> BUSY -> RESPOND -> RELEASE handshake FSM with a
// latency counter and a payload captured on acceptance.
module mem_resp_channel
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned LATENCY      = 2,
    parameter int unsigned PAYLOAD_BITS = 8,
    parameter bit          IS_READ      = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    valid_i,
    input  logic [1:0]              extra_lat_i,
    input  logic [PAYLOAD_BITS-1:0] payload_i,
    output logic [PAYLOAD_BITS-1:0] payload_o,
    output logic                    ready_o,
    output logic                    commit_o
);

    localparam logic [CntBits-1:0] LoadVal = CntBits'(LATENCY - 1);

    chan_state_e               state_q, state_d;
    logic [CntBits-1:0]        cnt_q, cnt_d, cnt_load;
    logic [PAYLOAD_BITS-1:0]   payload_q, payload_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        payload_d = payload_q;
        cnt_load  = LoadVal + CntBits'(extra_lat_i);
        case (state_q)
            StIdle: begin
                if (valid_i) begin
                    payload_d = payload_i;
                    if (cnt_load == '0) begin
                        state_d = StRespond;
                    end else begin
                        state_d = StBusy;
                        cnt_d   = cnt_load;
                    end
                end
            end
            StBusy: begin
                cnt_d = cnt_q - CntBits'(1);
                if (cnt_d == '0) begin
                    state_d = StRespond;
                end
            end
            StRespond: state_d = StRelease;
            StRelease: begin
                if (!valid_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            payload_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            payload_q <= payload_d;
        end
    end

    // payload_d equals the captured payload whenever commit_o is high, and also carries
    // the incoming payload on a direct IDLE->RESPOND acceptance.
    assign payload_o = payload_d;
    assign ready_o   = (state_q == StRespond);
    // Reads latch data on the edge entering RESPOND; writes commit on the edge leaving it.
    assign commit_o  = IS_READ ? (state_d == StRespond) : (state_q == StRespond);

endmodule

// File: rtl/data_mem_responder.sv
// Multi-channel memory responder with fixed request latency and a preload port.
// Define DATA_MEM_RESPONDER_JITTER_EN to add 0..3 cycles of LFSR-driven extra latency.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_BITS    = 8,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned LATENCY      = 2
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_CHANNELS-1:0]                mem_read_valid,
    input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_read_address,
    output logic [NUM_CHANNELS-1:0]                mem_read_ready,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_read_data,
    input  logic [NUM_CHANNELS-1:0]                mem_write_valid,
    input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_write_address,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_write_data,
    output logic [NUM_CHANNELS-1:0]                mem_write_ready,
    input  logic                                   load_en,
    input  logic [ADDR_BITS-1:0]                   load_address,
    input  logic [DATA_BITS-1:0]                   load_data
);

    localparam int unsigned Depth  = 1 << ADDR_BITS;
    localparam int unsigned WrBits = ADDR_BITS + DATA_BITS;

    logic [DATA_BITS-1:0]                   mem_q [Depth];
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] rdata_q, rdata_d;
    logic [ADDR_BITS-1:0]                   rd_addr    [NUM_CHANNELS];
    logic [WrBits-1:0]                      wr_payload [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]                rd_commit, wr_commit;
    logic [1:0]                             extra_lat;

`ifdef DATA_MEM_RESPONDER_JITTER_EN
    logic [7:0] lfsr_q, lfsr_d;

    always_comb lfsr_d = lfsr_next(lfsr_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= LfsrSeed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign extra_lat = lfsr_q[1:0];
`else
    assign extra_lat = 2'b00;
`endif

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        mem_resp_channel #(
            .LATENCY     (LATENCY),
            .PAYLOAD_BITS(ADDR_BITS),
            .IS_READ     (1'b1)
        ) u_rd (
            .clk_i      (clk),
            .reset_i    (reset),
            .valid_i    (mem_read_valid[c]),
            .extra_lat_i(extra_lat),
            .payload_i  (mem_read_address[c]),
            .payload_o  (rd_addr[c]),
            .ready_o    (mem_read_ready[c]),
            .commit_o   (rd_commit[c])
        );

        mem_resp_channel #(
            .LATENCY     (LATENCY),
            .PAYLOAD_BITS(WrBits),
            .IS_READ     (1'b0)
        ) u_wr (
            .clk_i      (clk),
            .reset_i    (reset),
            .valid_i    (mem_write_valid[c]),
            .extra_lat_i(extra_lat),
            .payload_i  ({mem_write_address[c], mem_write_data[c]}),
            .payload_o  (wr_payload[c]),
            .ready_o    (mem_write_ready[c]),
            .commit_o   (wr_commit[c])
        );
    end

    // Storage is never reset. Later assignments win: higher channel, then load port.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (wr_commit[c]) begin
                mem_q[wr_payload[c][WrBits-1:DATA_BITS]] <= wr_payload[c][DATA_BITS-1:0];
            end
        end
        if (load_en) begin
            mem_q[load_address] <= load_data;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (rd_commit[c]) begin
                rdata_d[c] = mem_q[rd_addr[c]];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign mem_read_data = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder at default parameters (LATENCY = 2).
module tb_data_mem_responder;

    logic            clk;
    logic            reset;
    logic [3:0]      rd_valid;
    logic [3:0][7:0] rd_addr;
    logic [3:0]      rd_ready;
    logic [3:0][7:0] rd_data;
    logic [3:0]      wr_valid;
    logic [3:0][7:0] wr_addr;
    logic [3:0][7:0] wr_data;
    logic [3:0]      wr_ready;
    logic            load_en;
    logic [7:0]      load_addr;
    logic [7:0]      load_data;

    int checks = 0;
    int passed = 0;

    data_mem_responder dut (
        .clk              (clk),
        .reset            (reset),
        .mem_read_valid   (rd_valid),
        .mem_read_address (rd_addr),
        .mem_read_ready   (rd_ready),
        .mem_read_data    (rd_data),
        .mem_write_valid  (wr_valid),
        .mem_write_address(wr_addr),
        .mem_write_data   (wr_data),
        .mem_write_ready  (wr_ready),
        .load_en          (load_en),
        .load_address     (load_addr),
        .load_data        (load_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        checks++; if (rd_ready !== 4'h0) $display("FAIL rst_rd_ready got %h want 0", rd_ready); else passed++;
        checks++; if (wr_ready !== 4'h0) $display("FAIL rst_wr_ready got %h want 0", wr_ready); else passed++;
        checks++; if (rd_data !== 32'h0) $display("FAIL rst_rd_data got %h want 0", rd_data); else passed++;
        preload(8'h10, 8'hAB);
        preload(8'h50, 8'h77);
        reset = 1'b0;
        tick();
        checks++; if (rd_ready !== 4'h0) $display("FAIL post_rst_rd_ready got %h want 0", rd_ready); else passed++;
        checks++; if (wr_ready !== 4'h0) $display("FAIL post_rst_wr_ready got %h want 0", wr_ready); else passed++;
        checks++; if (rd_data !== 32'h0) $display("FAIL post_rst_rd_data got %h want 0", rd_data); else passed++;
    endtask

    task automatic test_single_read;
        rd_valid[0] = 1'b1;
        rd_addr[0]  = 8'h10;
        tick();
        checks++; if (rd_ready !== 4'h0) $display("FAIL sr_early_ready got %h want 0", rd_ready); else passed++;
        rd_addr[0] = 8'h50;  // must be ignored after capture
        tick();
        checks++; if (rd_ready !== 4'b0001) $display("FAIL sr_ready got %h want 1", rd_ready); else passed++;
        checks++; if (rd_data[0] !== 8'hAB) $display("FAIL sr_data got %h want ab", rd_data[0]); else passed++;
        rd_valid[0] = 1'b0;
        tick();
        checks++; if (rd_ready !== 4'h0) $display("FAIL sr_ready_drop got %h want 0", rd_ready); else passed++;
        checks++; if (rd_data[0] !== 8'hAB) $display("FAIL sr_data_hold got %h want ab", rd_data[0]); else passed++;
        tick();
    endtask

    task automatic test_write_then_read;
        wr_valid[1] = 1'b1;
        wr_addr[1]  = 8'h20;
        wr_data[1]  = 8'h3C;
        tick();
        wr_data[1] = 8'h99;
        tick();
        checks++; if (wr_ready !== 4'b0010) $display("FAIL wtr_wr_ready got %h want 2", wr_ready); else passed++;
        wr_valid[1] = 1'b0;
        tick();
        checks++; if (wr_ready !== 4'h0) $display("FAIL wtr_wr_drop got %h want 0", wr_ready); else passed++;
        tick();
        rd_valid[2] = 1'b1;
        rd_addr[2]  = 8'h20;
        tick();
        tick();
        checks++; if (rd_ready !== 4'b0100) $display("FAIL wtr_rd_ready got %h want 4", rd_ready); else passed++;
        checks++; if (rd_data[2] !== 8'h3C) $display("FAIL wtr_rd_data got %h want 3c", rd_data[2]); else passed++;
        checks++; if (rd_data[0] !== 8'hAB) $display("FAIL wtr_ch0_hold got %h want ab", rd_data[0]); else passed++;
        rd_valid[2] = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_write_race;
        wr_valid   = 4'b1001;
        wr_addr[0] = 8'h40;
        wr_data[0] = 8'h11;
        wr_addr[3] = 8'h40;
        wr_data[3] = 8'h22;
        tick();
        tick();
        checks++; if (wr_ready !== 4'b1001) $display("FAIL race_wr_ready got %h want 9", wr_ready); else passed++;
        wr_valid = 4'b0000;
        tick();
        tick();
        rd_valid[0] = 1'b1;
        rd_addr[0]  = 8'h40;
        tick();
        tick();
        checks++; if (rd_data[0] !== 8'h22) $display("FAIL race_data got %h want 22", rd_data[0]); else passed++;
        rd_valid[0] = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_load_priority;
        wr_valid[1] = 1'b1;
        wr_addr[1]  = 8'h60;
        wr_data[1]  = 8'h33;
        tick();
        tick();
        // The write commits on the next edge; the load on that same edge must win.
        wr_valid[1] = 1'b0;
        load_en     = 1'b1;
        load_addr   = 8'h60;
        load_data   = 8'h44;
        tick();
        load_en = 1'b0;
        tick();
        rd_valid[1] = 1'b1;
        rd_addr[1]  = 8'h60;
        tick();
        tick();
        checks++; if (rd_data[1] !== 8'h44) $display("FAIL loadprio_data got %h want 44", rd_data[1]); else passed++;
        rd_valid[1] = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_valid_held;
        rd_valid[1] = 1'b1;
        rd_addr[1]  = 8'h10;
        tick();
        tick();
        checks++; if (rd_ready !== 4'b0010) $display("FAIL held_first got %h want 2", rd_ready); else passed++;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (rd_ready !== 4'h0) $display("FAIL held_no_repeat%0d got %h want 0", i, rd_ready); else passed++;
        end
        rd_valid[1] = 1'b0;
        tick();
        checks++; if (rd_ready !== 4'h0) $display("FAIL held_release got %h want 0", rd_ready); else passed++;
        rd_valid[1] = 1'b1;
        tick();
        checks++; if (rd_ready !== 4'h0) $display("FAIL held_reaccept got %h want 0", rd_ready); else passed++;
        tick();
        checks++; if (rd_ready !== 4'b0010) $display("FAIL held_second got %h want 2", rd_ready); else passed++;
        rd_valid[1] = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_busy;
        wr_valid[2] = 1'b1;
        wr_addr[2]  = 8'h50;
        wr_data[2]  = 8'hFF;
        tick();
        reset = 1'b1;
        #1;
        checks++; if (wr_ready !== 4'h0) $display("FAIL rmb_wr_ready got %h want 0", wr_ready); else passed++;
        checks++; if (rd_data !== 32'h0) $display("FAIL rmb_rd_data got %h want 0", rd_data); else passed++;
        wr_valid[2] = 1'b0;
        tick();
        tick();
        checks++; if (wr_ready !== 4'h0) $display("FAIL rmb_wr_ready_late got %h want 0", wr_ready); else passed++;
        reset = 1'b0;
        tick();
        rd_valid   = 4'b1001;
        rd_addr[0] = 8'h50;
        rd_addr[3] = 8'h10;
        tick();
        tick();
        checks++; if (rd_ready !== 4'b1001) $display("FAIL rmb_rd_ready got %h want 9", rd_ready); else passed++;
        checks++; if (rd_data[0] !== 8'h77) $display("FAIL rmb_kept_50 got %h want 77", rd_data[0]); else passed++;
        checks++; if (rd_data[3] !== 8'hAB) $display("FAIL rmb_kept_10 got %h want ab", rd_data[3]); else passed++;
        rd_valid = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_concurrent_reads;
        for (int i = 0; i < 4; i++) begin
            preload(8'h80 + 8'(i), 8'hA0 + 8'(i));
        end
        rd_valid = 4'hF;
        rd_addr  = 32'h83828180;
        tick();
        checks++; if (rd_ready !== 4'h0) $display("FAIL conc_early got %h want 0", rd_ready); else passed++;
        tick();
        checks++; if (rd_ready !== 4'hF) $display("FAIL conc_ready got %h want f", rd_ready); else passed++;
        checks++; if (rd_data !== 32'hA3A2A1A0) $display("FAIL conc_data got %h want a3a2a1a0", rd_data); else passed++;
        rd_valid = 4'h0;
        tick();
        checks++; if (rd_ready !== 4'h0) $display("FAIL conc_drop got %h want 0", rd_ready); else passed++;
        tick();
    endtask

    task automatic test_addr_boundary;
        preload(8'hFF, 8'h5E);
        rd_valid[2] = 1'b1;
        rd_addr[2]  = 8'hFF;
        wr_valid[3] = 1'b1;
        wr_addr[3]  = 8'h00;
        wr_data[3]  = 8'hC7;
        tick();
        tick();
        checks++; if (rd_data[2] !== 8'h5E) $display("FAIL bnd_ff got %h want 5e", rd_data[2]); else passed++;
        rd_valid[2] = 1'b0;
        wr_valid[3] = 1'b0;
        tick();
        tick();
        rd_valid[1] = 1'b1;
        rd_addr[1]  = 8'h00;
        tick();
        tick();
        checks++; if (rd_data[1] !== 8'hC7) $display("FAIL bnd_00 got %h want c7", rd_data[1]); else passed++;
        rd_valid[1] = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        rd_valid  = '0;
        rd_addr   = '0;
        wr_valid  = '0;
        wr_addr   = '0;
        wr_data   = '0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        test_reset();
        test_single_read();
        test_write_then_read();
        test_write_race();
        test_load_priority();
        test_valid_held();
        test_reset_mid_busy();
        test_concurrent_reads();
        test_addr_boundary();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
